// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute handshake, next-PC selection with
// return > call > jump > branch > sequential priority, and a small return-address stack.

module pc_sequencer #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_current,
    input  logic            fetch_ack,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jump_target,
    output logic            fetch_req,
    output logic [PC_W-1:0] next_pc,
    output logic            hold_pc,
    output logic            flush,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [SP_W-1:0]  sp_r;
    logic [PC_W-1:0]  ras_r [RAS_DEPTH];
    logic             ovf_r;
    logic             unf_r;

    logic             push_s;
    logic             pop_s;
    logic             set_ovf_s;
    logic             set_unf_s;
    logic             ras_empty_s;
    logic             ras_full_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [PC_W-1:0]  ras_top_s;
    logic [PC_W-1:0]  ret_addr_s;

    assign ret_addr_s  = pc_incr(pc_current);
    assign ras_empty_s = (sp_r == {SP_W{1'b0}});
    assign ras_full_s  = (sp_r == SP_FULL);
    // When empty the top index wraps to a harmless slot; it is never used then.
    assign top_idx_s   = IDX_W'(sp_r - SP_ONE);
    assign push_idx_s  = IDX_W'(sp_r);
    assign ras_top_s   = ras_r[top_idx_s];

    assign ras_overflow  = ovf_r;
    assign ras_underflow = unf_r;

    // Next-state, next-PC selection and stack request decode.
    always_comb begin
        state_next_s = state_r;
        fetch_req    = 1'b0;
        hold_pc      = 1'b1;
        flush        = 1'b0;
        next_pc      = pc_current;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        set_ovf_s    = 1'b0;
        set_unf_s    = 1'b0;
        if (rst) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_FETCH;
                end
                ST_FETCH: begin
                    fetch_req = 1'b1;
                    if (fetch_ack) begin
                        state_next_s = ST_EXEC;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    if (stall) begin
                        state_next_s = ST_EXEC;
                    end else begin
                        state_next_s = ST_FETCH;
                        hold_pc      = 1'b0;
                        if (ret) begin
                            flush = 1'b1;
                            if (!ras_empty_s) begin
                                next_pc = ras_top_s;
                                pop_s   = 1'b1;
                            end else begin
                                next_pc   = ret_addr_s;
                                set_unf_s = 1'b1;
                            end
                        end else if (call) begin
                            flush   = 1'b1;
                            next_pc = jump_target;
                            if (!ras_full_s) begin
                                push_s = 1'b1;
                            end else begin
                                set_ovf_s = 1'b1;
                            end
                        end else if (jump) begin
                            flush   = 1'b1;
                            next_pc = jump_target;
                        end else if (branch_taken) begin
                            flush   = 1'b1;
                            next_pc = branch_target;
                        end else begin
                            next_pc = ret_addr_s;
                        end
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, stack pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sp_r    <= {SP_W{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (push_s) begin
                sp_r <= sp_r + SP_ONE;
            end else if (pop_s) begin
                sp_r <= sp_r - SP_ONE;
            end else begin
                sp_r <= sp_r;
            end
            ovf_r <= ovf_r | set_ovf_s;
            unf_r <= unf_r | set_unf_s;
        end
    end

    // Return-address storage; contents survive reset, only the pointer clears.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_r[push_idx_s] <= ret_addr_s;
        end
    end

    pc_sequencer_checker #(
        .SP_W      (SP_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .hold_pc   (hold_pc),
        .flush     (flush),
        .sp        (sp_r)
    );

endmodule

// Structural invariants of the sequencer outputs and stack pointer.
module pc_sequencer_checker #(
    parameter int SP_W      = 3,
    parameter int RAS_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            fetch_req,
    input logic            hold_pc,
    input logic            flush,
    input logic [SP_W-1:0] sp
);

    a_flush_updates_pc: assert property (@(posedge clk) disable iff (rst) flush |-> !hold_pc);
    a_fetch_holds_pc:   assert property (@(posedge clk) disable iff (rst) fetch_req |-> hold_pc);
    a_sp_in_range:      assert property (@(posedge clk) disable iff (rst) sp <= SP_W'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts every PC update.
`timescale 1ns/1ps

module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_cur;
    logic       fetch_ack, stall, branch_taken, jump, call, ret;
    logic [7:0] branch_target, jump_target;
    logic       fetch_req, hold_pc, flush, ras_overflow, ras_underflow;
    logic [7:0] next_pc;

    pc_sequencer #(.PC_W(8), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_current    (pc_cur),
        .fetch_ack     (fetch_ack),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .fetch_req     (fetch_req),
        .next_pc       (next_pc),
        .hold_pc       (hold_pc),
        .flush         (flush),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // The PC register the sequencer controls.
    always @(posedge clk) begin
        if (!hold_pc) pc_cur <= next_pc;
    end

    typedef struct {
        logic [7:0] npc;
        logic       fl;
        logic       ovf;
        logic       unf;
        int         holds;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_stack[$];
    logic [7:0] model_pc;
    logic       model_ovf, model_unf;
    logic       first_v;
    logic       exp_fetch;
    logic       mon_en;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle handshake checks, scoreboard pop on every PC update.
    int   hold_cnt = 0;
    logic flag_pend = 1'b0;
    logic pend_ovf, pend_unf;
    always @(negedge clk) begin
        if (!mon_en) begin
            hold_cnt  = 0;
            flag_pend = 1'b0;
        end else begin
            if (flag_pend) begin
                check("ras_overflow", ras_overflow, pend_ovf);
                check("ras_underflow", ras_underflow, pend_unf);
                flag_pend = 1'b0;
            end
            check("fetch_req", fetch_req, exp_fetch);
            if (hold_pc) begin
                hold_cnt++;
                check("flush_on_hold", flush, 1'b0);
                check("next_pc_on_hold", next_pc, pc_cur);
            end else if (exp_q.size() == 0) begin
                check("unexpected_update", 32'd1, 32'd0);
                hold_cnt = 0;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("next_pc", next_pc, e.npc);
                check("flush", flush, e.fl);
                check("hold_cycles", hold_cnt, e.holds);
                pend_ovf  = e.ovf;
                pend_unf  = e.unf;
                flag_pend = 1'b1;
                hold_cnt  = 0;
            end
        end
    end

    // Predicts the outcome of one instruction, then drives its fetch and execute cycles.
    task automatic run_instr(input int dly, input int stl, input logic r, input logic c,
                             input logic j, input logic b, input logic [7:0] jt,
                             input logic [7:0] bt);
        exp_t       e;
        logic [7:0] inc;
        inc = model_pc + 8'd1;
        e.fl = 1'b1;
        if (r) begin
            if (model_stack.size() > 0) e.npc = model_stack.pop_back();
            else begin
                e.npc = inc;
                model_unf = 1'b1;
            end
        end else if (c) begin
            if (model_stack.size() < 4) model_stack.push_back(inc);
            else model_ovf = 1'b1;
            e.npc = jt;
        end else if (j) e.npc = jt;
        else if (b) e.npc = bt;
        else begin
            e.npc = inc;
            e.fl  = 1'b0;
        end
        e.ovf   = model_ovf;
        e.unf   = model_unf;
        e.holds = (first_v ? 1 : 0) + dly + 1 + stl;
        first_v = 1'b0;
        model_pc = e.npc;
        exp_q.push_back(e);

        ret = r; call = c; jump = j; branch_taken = b;
        jump_target = jt; branch_target = bt;
        exp_fetch = 1'b1;
        stall = 1'($urandom_range(0, 1));
        for (int i = 0; i < dly; i++) begin
            fetch_ack = 1'b0;
            cyc();
        end
        fetch_ack = 1'b1;
        cyc();
        exp_fetch = 1'b0;
        fetch_ack = 1'($urandom_range(0, 1));
        for (int i = 0; i < stl; i++) begin
            stall = 1'b1;
            cyc();
        end
        stall = 1'b0;
        cyc();
    endtask

    task automatic start_after_reset();
        rst       = 1'b0;
        exp_fetch = 1'b0;
        mon_en    = 1'b1;
        first_v   = 1'b1;
        cyc();
    endtask

    task automatic idle_fetch(input int n);
        ret = 1'b0; call = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        fetch_ack = 1'b0; stall = 1'b0; exp_fetch = 1'b1;
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pc_before;
        rst = 1'b1; pc_cur = 8'h00; mon_en = 1'b0; exp_fetch = 1'b0; first_v = 1'b0;
        fetch_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        call = 1'b0; ret = 1'b0; jump_target = 8'h00; branch_target = 8'h00;
        model_pc = 8'h00; model_ovf = 1'b0; model_unf = 1'b0;
        repeat (3) cyc();
        check("rst_fetch_req", fetch_req, 1'b0);
        check("rst_hold_pc", hold_pc, 1'b1);
        check("rst_flush", flush, 1'b0);
        check("rst_ras_overflow", ras_overflow, 1'b0);
        check("rst_ras_underflow", ras_underflow, 1'b0);
        start_after_reset();

        // Sequential from 00, then wrap at FF.
        repeat (3) run_instr(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        run_instr(0, 0, 0, 0, 1, 0, 8'hFF, 8'h00);
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        // Call from 10 to 40, return from 45 to 11.
        run_instr(0, 0, 0, 0, 1, 0, 8'h10, 8'h00);
        run_instr(0, 0, 0, 1, 0, 0, 8'h40, 8'h00);
        run_instr(1, 0, 0, 0, 1, 0, 8'h45, 8'h00);
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        // Five nested calls (overflow on the fifth), five returns (underflow on the fifth).
        for (int i = 0; i < 5; i++) run_instr(0, 0, 0, 1, 0, 0, 8'(8'h80 + 8'(i) * 8'h10), 8'h00);
        for (int i = 0; i < 5; i++) run_instr(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        // Stalled jump, all-requests-together pop, and a slow fetch.
        run_instr(0, 3, 0, 0, 1, 0, 8'h33, 8'h00);
        run_instr(0, 0, 0, 1, 0, 0, 8'h50, 8'h00);
        run_instr(0, 0, 1, 1, 1, 1, 8'h60, 8'h70);
        run_instr(4, 0, 0, 0, 0, 1, 8'h00, 8'h9A);
        run_instr(0, 1, 0, 0, 0, 1, 8'h00, 8'h2C);

        for (int n = 0; n < 150; n++) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Reset mid-EXEC with a jump pending: no PC update, flags and stack cleared.
        idle_fetch(1);
        mon_en = 1'b0;
        fetch_ack = 1'b1;
        cyc();
        fetch_ack = 1'b0; jump = 1'b1; jump_target = 8'h77; stall = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_exec_hold_pc", hold_pc, 1'b1);
        check("rst_exec_flush", flush, 1'b0);
        check("rst_exec_fetch_req", fetch_req, 1'b0);
        check("rst_exec_next_pc", next_pc, model_pc);
        pc_before = pc_cur;
        @(posedge clk);
        #1;
        check("rst_exec_pc_kept", pc_cur, pc_before);
        check("rst_exec_ovf_clr", ras_overflow, 1'b0);
        check("rst_exec_unf_clr", ras_underflow, 1'b0);
        jump = 1'b0;
        model_stack.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        start_after_reset();
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        run_instr(0, 0, 0, 1, 0, 0, 8'hC8, 8'h00);
        run_instr(1, 1, 1, 0, 0, 0, 8'h00, 8'h00);
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

        idle_fetch(3);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
